// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg: shared ALUOp encodings and ALU control enum for the RV32I execute stage.
package riscv_alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

endpackage

// File: rtl/riscv_alu_decoder.sv
// riscv_alu_decoder: maps ALUOp/funct3/funct7b5/op5 to a 3-bit ALU control plus an illegal flag.
module riscv_alu_decoder
    import riscv_alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_ctrl_e  control,
    output logic       illegal
);

    logic [3:0] key;

    // op5 gates funct7b5 so I-type instructions never decode to subtract
    assign key = {funct7b5 & op5, funct3};

    always_comb begin
        control = ALU_ADD;
        illegal = 1'b0;
        if (alu_op == ALUOP_SUB)
            control = ALU_SUB;
        else if (alu_op != ALUOP_ADD) begin
            casez (key)
                4'b0000: control = ALU_ADD;
                4'b1000: control = ALU_SUB;
                4'b?111: control = ALU_AND;
                4'b?110: control = ALU_OR;
                4'b?010: control = ALU_SLT;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/riscv_alu_unit.sv
// riscv_alu_unit: registered execute-stage ALU (add/sub/and/or/slt) with decoded control and zero flag.
module riscv_alu_unit
    import riscv_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             op5,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [2:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             valid_out
);

    alu_ctrl_e        ctrl;
    logic             ill;
    logic             sub_en;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res_next;

    riscv_alu_decoder u_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .op5      (op5),
        .control  (ctrl),
        .illegal  (ill)
    );

    assign sub_en = (ctrl[1:0] == 2'b01);
    assign sum    = src_a + (sub_en ? ~src_b : src_b) + {{(WIDTH-1){1'b0}}, sub_en};

    // slt takes the raw sign of a-b; no overflow correction
    always_comb begin
        res_next = '0;
        if (!ill) begin
            case (ctrl)
                ALU_ADD, ALU_SUB: res_next = sum;
                ALU_AND:          res_next = src_a & src_b;
                ALU_OR:           res_next = src_a | src_b;
                ALU_SLT:          res_next = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
                default:          res_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result      <= '0;
            zero        <= 1'b0;
            alu_control <= 3'b000;
            illegal     <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result      <= res_next;
                zero        <= (res_next == '0);
                alu_control <= ctrl;
                illegal     <= ill;
            end
        end
    end

endmodule

// File: tb/tb_riscv_alu_unit.sv
// tb_riscv_alu_unit: directed-vector self-checking bench for riscv_alu_unit.
module tb_riscv_alu_unit;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        op5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  alu_control;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_alu_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_in    (valid_in),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op5),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal),
        .valid_out   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic z,
                             input logic [2:0] ctl, input logic ill, input logic v);
        check({tag, ".result"},  result,      res);
        check({tag, ".zero"},    zero,        z);
        check({tag, ".control"}, alu_control, ctl);
        check({tag, ".illegal"}, illegal,     ill);
        check({tag, ".valid"},   valid_out,   v);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic o5, input logic [31:0] a, input logic [31:0] b);
        valid_in = v;
        alu_op   = op;
        funct3   = f3;
        funct7b5 = f7;
        op5      = o5;
        src_a    = a;
        src_b    = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        step();
        drive(1'b1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        step();
        check_out("reset", 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1);
        step();
        check_out("idle_after_reset", 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);

        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'h60, 32'h4);
        step();
        check_out("lw_add", 32'h64, 1'b0, 3'b000, 1'b0, 1'b1);

        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'h5, 32'h5);
        step();
        check_out("beq_taken", 32'h0, 1'b1, 3'b001, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 32'h5, 32'h7);
        step();
        check_out("rtype_sub", 32'hFFFFFFFE, 1'b0, 3'b001, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 32'h5, 32'h7);
        step();
        check_out("addi_f7", 32'h0000000C, 1'b0, 3'b000, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b1, 32'hC, 32'hA);
        step();
        check_out("and", 32'h8, 1'b0, 3'b010, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b1, 32'hC, 32'hA);
        step();
        check_out("or", 32'hE, 1'b0, 3'b011, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b010, 1'b0, 1'b1, 32'hC, 32'hA);
        step();
        check_out("slt_false", 32'h0, 1'b1, 3'b101, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b010, 1'b0, 1'b1, 32'h3, 32'h5);
        step();
        check_out("slt_true", 32'h1, 1'b0, 3'b101, 1'b0, 1'b1);

        drive(1'b1, 2'b11, 3'b010, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h1);
        step();
        check_out("slt_neg_f7", 32'h1, 1'b0, 3'b101, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b111, 1'b1, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00);
        step();
        check_out("and_f7", 32'hF000F000, 1'b0, 3'b010, 1'b0, 1'b1);

        drive(1'b1, 2'b10, 3'b001, 1'b1, 1'b1, 32'h5, 32'h7);
        step();
        check_out("illegal_001", 32'h0, 1'b1, 3'b000, 1'b1, 1'b1);

        drive(1'b1, 2'b11, 3'b100, 1'b0, 1'b0, 32'h5, 32'h7);
        step();
        check_out("illegal_100", 32'h0, 1'b1, 3'b000, 1'b1, 1'b1);

        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1);
        step();
        check_out("wrap_add", 32'h80000000, 1'b0, 3'b000, 1'b0, 1'b1);

        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'h0, 32'h1);
        step();
        check_out("wrap_sub", 32'hFFFFFFFF, 1'b0, 3'b001, 1'b0, 1'b1);

        drive(1'b0, 2'b10, 3'b110, 1'b0, 1'b1, 32'h1, 32'h2);
        step();
        check_out("hold1", 32'hFFFFFFFF, 1'b0, 3'b001, 1'b0, 1'b0);
        step();
        check_out("hold2", 32'hFFFFFFFF, 1'b0, 3'b001, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b1, 32'h1, 32'h2);
        step();
        check_out("b2b_or", 32'h3, 1'b0, 3'b011, 1'b0, 1'b1);
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 32'h10, 32'h20);
        step();
        check_out("b2b_add", 32'h30, 1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'h30, 32'h30);
        step();
        check_out("b2b_sub", 32'h0, 1'b1, 3'b001, 1'b0, 1'b1);

        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'hAAAA0000, 32'h5555);
        step();
        check_out("pre_async", 32'hAAAA5555, 1'b0, 3'b000, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b1, 32'hFFFF, 32'h0F0F);
        step();
        check_out("post_async", 32'h0F0F, 1'b0, 3'b010, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
